// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, image geometry and pixel/colour types.
// Latency: n/a (declarations only).
// Backpressure: n/a; the display path is free-running and never stalls.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_TOTAL  = 525;
    localparam int IMG_DIM  = 64;
    localparam int ADDR_W   = 12;

    // 12-bit colour, packed {r,g,b} so a 12'hRGB literal casts directly.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    // Per-pixel attributes travelling alongside the RAM read.
    typedef struct packed {
        logic valid;    // pipeline has been filled since reset
        logic visible;
        logic window;   // inside the replicated image
        logic border;   // image frame line (only ever set with VGA_BORDER_EN)
        logic hsync_n;
        logic vsync_n;
        logic first;    // pixel (0,0)
    } pix_flags_t;

endpackage

// File: rtl/vga_timing.sv
// Raster counters for 640x480@60: h 0..799, v 0..524, plus visible and raw sync flags.
// Latency: counters are registered; flags are decoded from the current count.
// Backpressure: none; counts every clock once reset_n is high.
// Ports: clock, reset_n (async, active-low) in; h, v, visible, hsync_n, vsync_n out.
module vga_timing
    import vga_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       visible,
    output logic       hsync_n,
    output logic       vsync_n
);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    always_comb begin
        visible = (h < H_VIS) && (v < V_VIS);
        hsync_n = !((h >= HS_START) && (h < HS_END));
        vsync_n = !((v >= VS_START) && (v < VS_END));
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Scans the 64x64x1 pixel RAM into a 640x480@60 VGA stream, image SCALE-replicated at top-left.
// Latency: 2 + RD_LATENCY cycles from raster counters to pins; all outputs registered.
// Backpressure: none; free-running. Define VGA_BORDER_EN to draw a FG frame around the image.
// Ports: clock, reset_n (async, active-low), rddata in; rdaddress, rden, hsync, vsync,
//        vga_r/g/b, frame_start out.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int          SCALE      = 4,
    parameter int          RD_LATENCY = 1,
    parameter logic [11:0] FG_COLOR   = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h008
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rddata,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              frame_start
);

    // SCALE is a power of two, so the divide is a shift.
    localparam int         SHIFT = $clog2(SCALE);
    localparam logic [9:0] WIN   = 10'(IMG_DIM * SCALE);

    logic [9:0] h;
    logic [9:0] v;
    logic       visible;
    logic       hsync_n;
    logic       vsync_n;

    vga_timing u_timing (
        .clock   (clock),
        .reset_n (reset_n),
        .h       (h),
        .v       (v),
        .visible (visible),
        .hsync_n (hsync_n),
        .vsync_n (vsync_n)
    );

    // ---------------- stage 0 decode ----------------
    logic [9:0] hx;
    logic [9:0] vy;
    logic       window;
    logic       border;

    always_comb begin
        hx     = h >> SHIFT;
        vy     = v >> SHIFT;
        window = visible && (h < WIN) && (v < WIN);
`ifdef VGA_BORDER_EN
        // One pixel line just right of and just below the image; never a RAM read.
        border = visible && (((h == WIN) && (v <= WIN)) || ((v == WIN) && (h <= WIN)));
`else
        border = 1'b0;
`endif
    end

    // ---------------- stage 1: RAM address ----------------
    pix_flags_t s1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdaddress <= '0;
            rden      <= 1'b0;
            s1        <= '0;
        end else begin
            rden <= window;
            // Address holds outside the window so the RAM port sees no needless toggling.
            if (window) begin
                rdaddress <= {vy[5:0], hx[5:0]};
            end
            s1 <= '{valid:   1'b1,
                    visible: visible,
                    window:  window,
                    border:  border,
                    hsync_n: hsync_n,
                    vsync_n: vsync_n,
                    first:   (h == 10'd0) && (v == 10'd0)};
        end
    end

    // ---------------- flag delay to match RAM read latency ----------------
    pix_flags_t dly [RD_LATENCY];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= s1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    // ---------------- output stage ----------------
    pix_flags_t tail;
    color_t     color_q;

    assign tail = dly[RD_LATENCY-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            color_q     <= '0;
            frame_start <= 1'b0;
        end else if (!tail.valid) begin
            // Pipeline not yet filled: keep idle levels, no spurious sync edges.
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            color_q     <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= tail.hsync_n;
            vsync       <= tail.vsync_n;
            frame_start <= tail.first;
            if (!tail.visible) begin
                color_q <= '0;
            end else if (tail.window) begin
                color_q <= rddata ? color_t'(FG_COLOR) : color_t'(BG_COLOR);
            end else if (tail.border) begin
                color_q <= color_t'(FG_COLOR);
            end else begin
                color_q <= color_t'(BG_COLOR);
            end
        end
    end

    assign vga_r = color_q.r;
    assign vga_g = color_q.g;
    assign vga_b = color_q.b;

endmodule
